// File: rtl/mem_port_demux_pkg.sv
// Shared definitions for the instruction/data memory return-path demux.
//   NOP_INSTR_DEFAULT : instruction held on the fetch output after reset/flush
//                       (addi x0,x0,0).
//   PHASE_FETCH/DATA  : encoding of the phase bit that drives the address mux.
//   phase_e           : FSM state type built on that encoding.
package mem_port_demux_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic PHASE_FETCH = 1'b0;
  localparam logic PHASE_DATA  = 1'b1;

  typedef enum logic {
    PH_FETCH = PHASE_FETCH,
    PH_DATA  = PHASE_DATA
  } phase_e;

endpackage

// File: rtl/mem_port_demux_reg.sv
// N-bit register with a synchronous reset to a value supplied on a port,
// and a load enable.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, loads rst_val
//   rst_val : value taken on reset
//   en      : load d at the edge
//   d       : next value
//   q       : registered value
module nbit_en_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_demux.sv
// Return-path demultiplexer for the shared instruction/data memory.
// A two-state phase FSM alternates FETCH and DATA cycles; the phase bit is
// driven straight out on sel (and is the observable FSM state). Read data is
// captured into the instruction register in FETCH and into the load register
// in DATA when a load is pending.
//   clk, rst   : clock, synchronous active-high reset
//   stall      : freeze phase, hold outputs, drop strobes
//   flush      : discard in-flight fetch, force NOP, return to FETCH
//   data_req   : load pending in the current DATA phase
//   mem_rdata  : asynchronous memory read data
//   sel        : phase (0 = FETCH / PC address, 1 = DATA / ALU address)
//   inst_out   : registered instruction, inst_valid one-cycle strobe
//   load_out   : registered load data, load_valid one-cycle strobe
//   pc_en      : PC may advance this cycle
// Handshake: inst_valid / load_valid are pure strobes with no back-pressure;
// the consumer must take the value in the cycle the strobe is high.
module mem_port_demux
  import mem_port_demux_pkg::*;
#(
  parameter int          N         = 32,
  parameter logic [N-1:0] NOP_INSTR = N'(NOP_INSTR_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         data_req,
  input  logic [N-1:0] mem_rdata,
  output logic         sel,
  output logic [N-1:0] inst_out,
  output logic         inst_valid,
  output logic [N-1:0] load_out,
  output logic         load_valid,
  output logic         pc_en
);

  phase_e       state, state_nxt;
  logic         inst_en, load_en;
  logic [N-1:0] inst_d;
  logic         inst_valid_nxt, load_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PH_FETCH;
      inst_valid <= 1'b0;
      load_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      inst_valid <= inst_valid_nxt;
      load_valid <= load_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    inst_en        = 1'b0;
    inst_d         = mem_rdata;
    load_en        = 1'b0;
    inst_valid_nxt = 1'b0;
    load_valid_nxt = 1'b0;
    if (flush) begin
      // Flush wins over stall. The fetch register is overwritten with a NOP,
      // but a load in DATA belongs to an older, committed instruction and
      // still lands.
      state_nxt = PH_FETCH;
      inst_en   = 1'b1;
      inst_d    = NOP_INSTR;
      if (state == PH_DATA && data_req) begin
        load_en        = 1'b1;
        load_valid_nxt = 1'b1;
      end
    end else if (!stall) begin
      case (state)
        PH_FETCH: begin
          inst_en        = 1'b1;
          inst_valid_nxt = 1'b1;
          state_nxt      = PH_DATA;
        end
        PH_DATA: begin
          if (data_req) begin
            load_en        = 1'b1;
            load_valid_nxt = 1'b1;
          end
          state_nxt = PH_FETCH;
        end
        default: state_nxt = PH_FETCH;
      endcase
    end
  end

  assign sel   = state;
  assign pc_en = (state == PH_DATA) && !stall && !flush;

  nbit_en_reg #(.W(N)) u_inst_reg (
    .clk     (clk),
    .rst     (rst),
    .rst_val (NOP_INSTR),
    .en      (inst_en),
    .d       (inst_d),
    .q       (inst_out)
  );

  nbit_en_reg #(.W(N)) u_load_reg (
    .clk     (clk),
    .rst     (rst),
    .rst_val ('0),
    .en      (load_en),
    .d       (mem_rdata),
    .q       (load_out)
  );

endmodule

// File: tb/tb_mem_port_demux.sv
module tb_mem_port_demux;

  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, stall, flush, data_req;
  logic [W-1:0] mem_rdata;
  logic         sel, inst_valid, load_valid, pc_en;
  logic [W-1:0] inst_out, load_out;

  mem_port_demux dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .data_req   (data_req),
    .mem_rdata  (mem_rdata),
    .sel        (sel),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .load_out   (load_out),
    .load_valid (load_valid),
    .pc_en      (pc_en)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: "in_data" says the next edge belongs to a data slot
  bit           m_in_data;
  logic [W-1:0] m_inst, m_load;
  bit           m_iv, m_lv;
  logic [W-1:0] exp_q[$];   // fetched words awaiting their inst_valid strobe

  task automatic model_reset();
    m_in_data = 0; m_inst = NOP; m_load = '0; m_iv = 0; m_lv = 0;
    exp_q.delete();
  endtask

  // One clock: apply inputs, check pc_en, advance model, check registered outputs.
  task automatic step(input logic r, input logic s, input logic f, input logic d,
                      input logic [W-1:0] rd);
    rst = r; stall = s; flush = f; data_req = d; mem_rdata = rd;
    #1;
    check("pc_en", W'(pc_en), W'(m_in_data && !s && !f));
    if (r) begin
      model_reset();
    end else if (f) begin
      m_lv = m_in_data && d;
      if (m_lv) m_load = rd;
      m_inst = NOP; m_iv = 0; m_in_data = 0;
      exp_q.delete();
    end else if (s) begin
      m_iv = 0; m_lv = 0;
    end else if (!m_in_data) begin
      m_inst = rd; m_iv = 1; m_lv = 0; m_in_data = 1;
      exp_q.push_back(rd);
    end else begin
      m_iv = 0; m_lv = d;
      if (d) m_load = rd;
      m_in_data = 0;
    end
    @(posedge clk);
    #1;
    check("sel",        W'(sel),        W'(m_in_data));
    check("inst_out",   inst_out,       m_inst);
    check("inst_valid", W'(inst_valid), W'(m_iv));
    check("load_out",   load_out,       m_load);
    check("load_valid", W'(load_valid), W'(m_lv));
    if (inst_valid) begin
      if (exp_q.size() == 0) check("inst_sb_empty", W'(1), W'(0));
      else                   check("inst_sb", inst_out, exp_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; data_req = 1'b0; mem_rdata = '0;
    // 1. reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_sel",  W'(sel),        W'(0));
    check("rst_inst", inst_out,       NOP);
    check("rst_load", load_out,       '0);
    check("rst_iv",   W'(inst_valid), W'(0));
    check("rst_lv",   W'(load_valid), W'(0));
    step(0, 0, 0, 0, 32'h00A0_0093);
    check("first_fetch", inst_out, 32'h00A0_0093);
    check("first_iv",    W'(inst_valid), W'(1));

    // 2. free-running without loads
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h11);
    step(0, 0, 0, 0, 32'h22);
    check("free_inst1", inst_out, 32'h11);
    step(0, 0, 0, 0, 32'h33);
    step(0, 0, 0, 0, 32'h44);
    check("free_inst2", inst_out, 32'h33);
    check("free_lv",    W'(load_valid), W'(0));

    // 3. load in DATA
    step(0, 0, 0, 0, 32'h55);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    check("load_data", load_out, 32'hDEAD_BEEF);
    check("load_lv",   W'(load_valid), W'(1));
    check("load_inst", inst_out, 32'h55);

    // 4. stall three cycles starting in DATA
    step(0, 0, 0, 0, 32'h66);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, $urandom);
      check("stall_sel", W'(sel), W'(1));
      check("stall_inst", inst_out, 32'h66);
    end
    step(0, 0, 0, 1, 32'h77);
    check("stall_rel_load", load_out, 32'h77);
    step(0, 0, 0, 0, 32'h88);
    check("stall_rel_fetch", inst_out, 32'h88);

    // 5. flush in FETCH with stall, then flush in DATA with a load
    step(0, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 32'h1234_5678);
    check("flushf_inst", inst_out, NOP);
    check("flushf_iv",   W'(inst_valid), W'(0));
    check("flushf_sel",  W'(sel), W'(0));
    step(0, 0, 0, 0, 32'h99);
    step(0, 0, 1, 1, 32'hCAFE_0001);
    check("flushd_load", load_out, 32'hCAFE_0001);
    check("flushd_lv",   W'(load_valid), W'(1));
    check("flushd_inst", inst_out, NOP);

    // 6. reset in DATA with a load pending
    step(0, 0, 0, 0, 32'hAA);
    step(1, 0, 0, 1, 32'hBBBB_BBBB);
    check("rstd_lv",   W'(load_valid), W'(0));
    check("rstd_load", load_out, '0);
    check("rstd_sel",  W'(sel), W'(0));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1) == 1,
           $urandom);
    end

    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_demux.md
Name: mem_port_demux

Overview:
- Return-path demultiplexer for the single-ported instruction/data memory in the pipelined RISC-V core.
- An internal phase register alternates FETCH and DATA cycles and drives `sel` to the address-side 2x1 N-bit mux.
- Memory read data is steered to either a registered instruction output (IF/ID side) or a registered load-data output (MEM/WB side).
- Each output has a one-cycle valid strobe, plus a PC-advance enable; stall and flush are handled here.

Parameters:
- N, 32, data/instruction width in bits.
- NOP_INSTR, 32'h00000013, value held on `inst_out` after reset or flush (`addi x0,x0,0`).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- stall  input  1  freeze phase and hold outputs (load-use or external hazard).
- flush  input  1  branch/jump taken; discard the fetch in flight.
- data_req  input  1  MEM stage has a load in the current DATA phase.
- mem_rdata  input  N  asynchronous read data from the shared memory.
- sel  output  1  phase: 0 = FETCH (PC address), 1 = DATA (ALU address); drives the address mux.
- inst_out  output  N  registered instruction.
- inst_valid  output  1  one-cycle strobe: `inst_out` updated this cycle.
- load_out  output  N  registered load data.
- load_valid  output  1  one-cycle strobe: `load_out` updated this cycle.
- pc_en  output  1  PC may advance this cycle.

Behaviour:
- Reset, synchronous and active-high, overrides all other inputs:
  - phase = FETCH, so `sel` = 0.
  - `inst_out` = NOP_INSTR, `load_out` = 0.
  - `inst_valid` = `load_valid` = 0.
- Reset asserted mid-operation takes effect at the next edge. Any capture in progress is lost.
- FSM has two states, FETCH and DATA. `sel` is the registered phase bit; it is not decoded combinationally.
- FETCH, with no stall and no flush:
  - At the edge: `inst_out` <= `mem_rdata`, `inst_valid` <= 1, phase <= DATA.
- DATA, with no stall:
  - If `data_req` = 1: `load_out` <= `mem_rdata`, `load_valid` <= 1.
  - Otherwise `load_out` holds and `load_valid` <= 0.
  - Phase <= FETCH.
- Latency: capture is registered, so data appears 1 cycle after its phase. The fetch rate is one instruction per 2 cycles.
- Valid strobes are high for exactly one cycle per capture and are never asserted in consecutive cycles.
- `pc_en` = (phase == DATA) && !stall && !flush. It is combinational from phase and inputs, so the PC advances once per instruction pair of cycles.
- stall = 1 (and flush = 0):
  - Phase is frozen.
  - `inst_out` and `load_out` hold.
  - Both valids <= 0.
  - `pc_en` = 0.
- flush = 1 (priority over stall):
  - `inst_out` <= NOP_INSTR and `inst_valid` <= 0.
  - Phase <= FETCH.
  - If flush occurs in DATA with `data_req` = 1, the load capture still occurs, because the older instruction is committed.
  - If flush occurs in FETCH, the fetched word is discarded.
- `data_req` sampled during FETCH is ignored; a load never captures in FETCH.
- Width: all data paths are N bits with no extension. Sign/zero extension of loads is done downstream.

Decomposition:
- Shared defines header holds:
  - NOP_INSTR.
  - PHASE_FETCH = 1'b0, PHASE_DATA = 1'b1.
- One sub-module is natural: `nbit_en_reg`, an N-bit register with sync reset-value input, load enable and reset-to-value.
  - Instantiate it twice: once for `inst_out` (reset value NOP_INSTR) and once for `load_out` (reset value 0).
- The FSM and strobes stay in the top.

Test Plan:
1. Reset sequence: rst=1 for 2 cycles, then release -> `sel`=0, `inst_out`=0x00000013, `load_out`=0, both valids 0. The first edge after release captures `mem_rdata`=0x00A00093, and `inst_valid`=1 for 1 cycle.
2. Free-running, `data_req`=0 -> `sel` toggles 0,1,0,1 and `inst_valid` pulses every 2nd cycle. `mem_rdata` values 0x11,0x22,0x33,0x44 yield `inst_out` 0x11 then 0x33; `load_valid` stays 0.
3. Load in DATA, `data_req`=1, `mem_rdata`=0xDEADBEEF -> `load_out`=0xDEADBEEF and `load_valid`=1 one cycle later. `inst_out` is unchanged.
4. Stall for 3 cycles starting in DATA -> `sel` stays 1, outputs hold, valids 0, `pc_en`=0. After release, phase resumes DATA then FETCH with no lost or duplicated capture.
5. Flush in FETCH with simultaneous stall, `mem_rdata`=0x12345678 -> `inst_out`=0x00000013, `inst_valid`=0, `sel`=0 next cycle. Flush in DATA with `data_req`=1 still captures the load.
6. rst asserted in DATA while `data_req`=1 -> no `load_valid`, `load_out`=0, `sel`=0 next cycle.
